// File: rtl/npt_pkg.sv
// Shared constants and types for the NPT convolution engine.
// Holds default geometry, FSM state encoding and the kernel reset value.
package npt_pkg;

  localparam int NPT_IMG_W    = 8;
  localparam int NPT_IMG_H    = 8;
  localparam int NPT_K        = 3;
  localparam int NPT_DATA_W   = 8;
  localparam int NPT_ACC_W    = 20;
  localparam int NPT_KER_INIT = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_MAC   = 3'd2,
    ST_WRITE = 3'd3,
    ST_NEXT  = 3'd4,
    ST_DONE  = 3'd5
  } npt_state_e;

  // Address/counter width that stays legal for degenerate sizes of one.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/npt_mac.sv
// Multiply-accumulate unit: adds a*b to the running sum when enabled.
// A clear pulse zeroes the sum ahead of each new window.
module npt_mac
  import npt_pkg::*;
#(
  parameter int DATA_W = NPT_DATA_W,
  parameter int ACC_W  = NPT_ACC_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              clear,
  input  logic              enable,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);

  logic [2*DATA_W-1:0] product;
  logic [ACC_W-1:0]    acc_reg;

  assign product = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
  assign acc     = acc_reg;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      acc_reg <= '0;
    end else if (clear) begin
      acc_reg <= '0;
    end else if (enable) begin
      acc_reg <= acc_reg + ACC_W'(product);
    end
  end

endmodule

// File: rtl/npt_top.sv
// NPT accelerator top: valid-padding, stride-1 KxK convolution over an internal image.
// One kernel term is accumulated per cycle; each window sum lands in res_mem.
module npt_top
  import npt_pkg::*;
#(
  parameter int IMG_W  = NPT_IMG_W,
  parameter int IMG_H  = NPT_IMG_H,
  parameter int K      = NPT_K,
  parameter int DATA_W = NPT_DATA_W,
  parameter int ACC_W  = NPT_ACC_W
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  output logic       o_done,
  output logic [2:0] state
);

  localparam int OUT_W  = IMG_W - K + 1;
  localparam int OUT_H  = IMG_H - K + 1;
  localparam int IMG_N  = IMG_W * IMG_H;
  localparam int KER_N  = K * K;
  localparam int RES_N  = OUT_W * OUT_H;
  localparam int IMG_AW = clog2_min1(IMG_N);
  localparam int KER_AW = clog2_min1(KER_N);
  localparam int RES_AW = clog2_min1(RES_N);
  localparam int KR_W   = clog2_min1(K);
  localparam int ROW_W  = clog2_min1(OUT_H);
  localparam int COL_W  = clog2_min1(OUT_W);

  logic [DATA_W-1:0] img_mem  [IMG_N];
  logic [DATA_W-1:0] ker_mem  [KER_N];
  logic [ACC_W-1:0]  res_mem  [RES_N];
  logic [DATA_W-1:0] img_init [IMG_N];

  npt_state_e state_reg, state_next;
  logic       done_reg;
  logic [KR_W-1:0]  kr_reg, kr_next, kc_reg, kc_next;
  logic [ROW_W-1:0] out_r_reg, out_r_next;
  logic [COL_W-1:0] out_c_reg, out_c_next;

  logic              mac_clear, mac_en, res_we, last_out;
  logic [IMG_AW-1:0] img_addr;
  logic [KER_AW-1:0] ker_addr;
  logic [RES_AW-1:0] res_addr;
  logic [ACC_W-1:0]  acc;

  // Ramp image: each pixel holds its own linear index, wrapped to the pixel width.
  for (genvar gi = 0; gi < IMG_N; gi++) begin : g_img_init
    assign img_init[gi] = DATA_W'(gi);
  end

  assign img_addr = IMG_AW'((int'(out_r_reg) + int'(kr_reg)) * IMG_W
                            + int'(out_c_reg) + int'(kc_reg));
  assign ker_addr = KER_AW'(int'(kr_reg) * K + int'(kc_reg));
  assign res_addr = RES_AW'(int'(out_r_reg) * OUT_W + int'(out_c_reg));
  assign last_out = (out_r_reg == ROW_W'(OUT_H - 1)) && (out_c_reg == COL_W'(OUT_W - 1));

  assign o_done = done_reg;
  assign state  = state_reg;

  npt_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .clear  (mac_clear),
    .enable (mac_en),
    .a      (img_mem[img_addr]),
    .b      (ker_mem[ker_addr]),
    .acc    (acc)
  );

  always_comb begin
    state_next = state_reg;
    kr_next    = kr_reg;
    kc_next    = kc_reg;
    out_r_next = out_r_reg;
    out_c_next = out_c_reg;
    mac_clear  = 1'b0;
    mac_en     = 1'b0;
    res_we     = 1'b0;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          state_next = ST_CLEAR;
          out_r_next = '0;
          out_c_next = '0;
        end
      end
      ST_CLEAR: begin
        mac_clear  = 1'b1;
        kr_next    = '0;
        kc_next    = '0;
        state_next = ST_MAC;
      end
      ST_MAC: begin
        mac_en = 1'b1;
        if (kc_reg == KR_W'(K - 1)) begin
          kc_next = '0;
          if (kr_reg == KR_W'(K - 1)) begin
            state_next = ST_WRITE;
          end else begin
            kr_next = kr_reg + KR_W'(1);
          end
        end else begin
          kc_next = kc_reg + KR_W'(1);
        end
      end
      ST_WRITE: begin
        res_we     = 1'b1;
        state_next = ST_NEXT;
      end
      ST_NEXT: begin
        if (last_out) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_CLEAR;
          if (out_c_reg == COL_W'(OUT_W - 1)) begin
            out_c_next = '0;
            out_r_next = out_r_reg + ROW_W'(1);
          end else begin
            out_c_next = out_c_reg + COL_W'(1);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_reg <= ST_IDLE;
      done_reg  <= 1'b0;
      kr_reg    <= '0;
      kc_reg    <= '0;
      out_r_reg <= '0;
      out_c_reg <= '0;
    end else begin
      state_reg <= state_next;
      done_reg  <= (state_next == ST_DONE);
      kr_reg    <= kr_next;
      kc_reg    <= kc_next;
      out_r_reg <= out_r_next;
      out_c_reg <= out_c_next;
    end
  end

  // Image and kernel are only ever loaded by reset; results are written once per window.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < IMG_N; i++) img_mem[i] <= img_init[i];
      for (int i = 0; i < KER_N; i++) ker_mem[i] <= DATA_W'(NPT_KER_INIT);
      for (int i = 0; i < RES_N; i++) res_mem[i] <= '0;
    end else if (res_we) begin
      res_mem[res_addr] <= acc;
    end
  end

endmodule

// File: tb/tb_npt_top.sv
// Bench for npt_top: a timeline model predicts state, o_done and result memory every cycle,
// driven by directed runs plus randomized start noise and reset points.
module tb_npt_top;

  localparam int IMG_W   = 8;
  localparam int K       = 3;
  localparam int OUT_W   = 6;
  localparam int RES_N   = 36;
  localparam int PER_OUT = 1 + K * K + 1 + 1;
  localparam int RUN_CYC = RES_N * PER_OUT;

  logic       i_clk   = 1'b0;
  logic       i_rst   = 1'b1;
  logic       i_start = 1'b0;
  logic       o_done;
  logic [2:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  npt_top dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (i_start),
    .o_done  (o_done),
    .state   (state)
  );

  always #5 i_clk = ~i_clk;

  // Model: 0 idle, 1 running (t = edges since start was sampled), 2 done.
  int m_mode = 0;
  int m_t    = 0;
  int exp_res [RES_N];

  function automatic int window_sum(input int idx);
    int r, c, s;
    r = idx / OUT_W;
    c = idx % OUT_W;
    s = 0;
    for (int kr = 0; kr < K; kr++)
      for (int kc = 0; kc < K; kc++)
        s += (((r + kr) * IMG_W + c + kc) % 256) * 1;
    return s;
  endfunction

  function automatic int exp_state();
    int p;
    if (m_mode == 0) return 0;
    if (m_mode == 2) return 5;
    p = m_t % PER_OUT;
    if (p == 0) return 1;
    if (p <= K * K) return 2;
    if (p == K * K + 1) return 3;
    return 4;
  endfunction

  always @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      m_mode = 0;
      m_t    = 0;
      for (int i = 0; i < RES_N; i++) exp_res[i] = 0;
    end else begin
      case (m_mode)
        0, 2: if (i_start) begin m_mode = 1; m_t = 0; end
        default: begin
          if (m_t % PER_OUT == K * K + 1) exp_res[m_t / PER_OUT] = window_sum(m_t / PER_OUT);
          m_t++;
          if (m_t == RUN_CYC) m_mode = 2;
        end
      endcase
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge i_clk) begin
    int bad_i;
    check("cyc_state", int'(state), exp_state());
    check("cyc_done", int'(o_done), (m_mode == 2) ? 1 : 0);
    bad_i = -1;
    for (int i = 0; i < RES_N; i++)
      if (bad_i < 0 && int'(dut.res_mem[i]) != exp_res[i]) bad_i = i;
    n_cmp++;
    if (bad_i >= 0) begin
      n_bad++;
      $display("FAIL cyc_res[%0d]: got %0d expected %0d at %0t",
               bad_i, int'(dut.res_mem[bad_i]), exp_res[bad_i], $time);
    end
  end

  task automatic start_pulse();
    @(negedge i_clk);
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    check("start_state", int'(state), 1);
    check("start_done", int'(o_done), 0);
  endtask

  task automatic wait_done(input bit noisy, output int edges);
    edges = 0;
    while (!o_done && edges < 1000) begin
      @(posedge i_clk);
      #1;
      edges++;
      i_start = noisy ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
    i_start = 1'b0;
  endtask

  task automatic check_literals(input string tag);
    check({tag, "_res0"},  int'(dut.res_mem[0]),  81);
    check({tag, "_res1"},  int'(dut.res_mem[1]),  90);
    check({tag, "_res6"},  int'(dut.res_mem[6]),  153);
    check({tag, "_res35"}, int'(dut.res_mem[35]), 486);
  endtask

  task automatic assert_reset(input string tag);
    @(posedge i_clk);
    #2;
    i_rst = 1'b0;
    #1;
    check({tag, "_state"}, int'(state), 0);
    check({tag, "_done"}, int'(o_done), 0);
    check({tag, "_res0"}, int'(dut.res_mem[0]), 0);
    @(negedge i_clk);
    i_rst = 1'b1;
  endtask

  initial begin
    int edges, cut;

    #1 i_rst = 1'b0;
    repeat (3) @(negedge i_clk);
    check("rst_state", int'(state), 0);
    check("rst_done", int'(o_done), 0);
    check("rst_res35", int'(dut.res_mem[35]), 0);
    i_rst = 1'b1;
    repeat (100) @(negedge i_clk);
    check("idle_state", int'(state), 0);
    $display("reset released, idle held for 100 cycles");

    start_pulse();
    wait_done(1'b0, edges);
    check("full_latency", edges, RUN_CYC);
    check_literals("full");
    $display("full run: done after %0d edges", edges);

    repeat (50) @(negedge i_clk);
    check("done_hold", int'(o_done), 1);
    start_pulse();
    wait_done(1'b1, edges);
    check("noisy_latency", edges, RUN_CYC);
    check_literals("noisy");
    $display("restart with start noise: done after %0d edges", edges);

    start_pulse();
    repeat (199) @(posedge i_clk);
    check("pre_abort_res0", int'(dut.res_mem[0]), 81);
    assert_reset("abort");
    $display("reset at cycle 200 of run");
    start_pulse();
    wait_done(1'b0, edges);
    check("post_abort_latency", edges, RUN_CYC);
    check_literals("post_abort");
    $display("run after abort: done after %0d edges", edges);

    for (int it = 0; it < 3; it++) begin
      cut = $urandom_range(1, RUN_CYC - 2);
      start_pulse();
      repeat (cut - 1) @(posedge i_clk);
      assert_reset("rand_abort");
      repeat ($urandom_range(1, 5)) @(negedge i_clk);
      start_pulse();
      wait_done(1'b1, edges);
      check("rand_latency", edges, RUN_CYC);
      $display("random episode %0d: abort at %0d, done after %0d edges", it, cut, edges);
    end

    @(negedge i_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
